// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB arbiter types and sizing: FU result payload and lane/FU counts.
package cdb_arbiter_pkg;
  localparam int NUM_FU    = 4;
  localparam int CDB_WIDTH = 2;
  localparam int PRF_IDX   = 6;
  localparam int ROB_IDX   = 5;
  localparam int ARCH_IDX  = 5;
  localparam int XLEN      = 32;
  localparam int FU_IDX_W  = $clog2(NUM_FU);

  typedef struct packed {
    logic [ROB_IDX-1:0]  rob_id;
    logic [PRF_IDX-1:0]  rd_phy;
    logic [ARCH_IDX-1:0] rd_arch;
    logic [XLEN-1:0]     rd_value;
  } fu_result_t;
endpackage

// File: rtl/cdb_arbiter_if.sv
// FU-result handshake and CDB broadcast bundle between FUs, arbiter and consumers.
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic       [NUM_FU-1:0]                fu_valid;
  logic       [NUM_FU-1:0]                fu_ready;
  fu_result_t [NUM_FU-1:0]                fu_result;
  logic       [CDB_WIDTH-1:0]             cdb_valid;
  fu_result_t [CDB_WIDTH-1:0]             cdb_result;
  logic       [CDB_WIDTH-1:0][FU_IDX_W-1:0] cdb_src;

  modport master (output fu_valid, fu_result,
                  input  fu_ready, cdb_valid, cdb_result, cdb_src);
  modport slave  (input  fu_valid, fu_result,
                  output fu_ready, cdb_valid, cdb_result, cdb_src);
endinterface

// File: rtl/cdb_arbiter_rr_multi_picker.sv
// Rotating multi-grant picker: first W requesters at or after ptr, one-hot per lane in scan order.
module rr_multi_picker #(
  parameter int N  = 4,
  parameter int W  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]        req,
  input  logic [IW-1:0]       ptr,
  output logic [W-1:0][N-1:0] grant,
  output logic [IW-1:0]       last_idx,
  output logic                any_grant
);
  logic [IW:0]   pos;
  logic [IW-1:0] idx;
  int            cnt;

  always_comb begin
    grant     = '0;
    last_idx  = ptr;
    any_grant = 1'b0;
    cnt       = 0;
    pos       = '0;
    idx       = '0;
    for (int j = 0; j < N; j++) begin
      // modulo-N walk that also works for non power-of-two N
      pos = {1'b0, ptr} + (IW+1)'(j);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      idx = pos[IW-1:0];
      for (int k = 0; k < W; k++) begin
        if (req[idx] && cnt == k) begin
          grant[k][idx] = 1'b1;
          last_idx      = idx;
          any_grant     = 1'b1;
        end
      end
      if (req[idx] && cnt < W) cnt = cnt + 1;
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Per-FU one-entry result buffers sharing CDB_WIDTH broadcast lanes round-robin.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);
  logic       [NUM_FU-1:0]                  buf_valid;
  fu_result_t [NUM_FU-1:0]                  buf_data;
  logic       [FU_IDX_W-1:0]                rr_ptr;
  logic       [CDB_WIDTH-1:0][NUM_FU-1:0]   grant;
  logic       [NUM_FU-1:0]                  granted;
  logic       [FU_IDX_W-1:0]                last_idx;
  logic                                     any_grant;
  logic                                     accept_en;
  logic       [CDB_WIDTH-1:0]               lane_vld;
  fu_result_t [CDB_WIDTH-1:0]               lane_res;
  logic       [CDB_WIDTH-1:0][FU_IDX_W-1:0] lane_src;

  rr_multi_picker #(.N(NUM_FU), .W(CDB_WIDTH), .IW(FU_IDX_W)) u_picker (
    .req       (buf_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .last_idx  (last_idx),
    .any_grant (any_grant)
  );

  always_comb begin
    granted = '0;
    for (int k = 0; k < CDB_WIDTH; k++) granted = granted | grant[k];
  end

  assign accept_en    = !rst && !flush;
  // a buffer leaving on the CDB this cycle can take a new result on the same edge
  assign bus.fu_ready = {NUM_FU{accept_en}} & (~buf_valid | granted);

  // lanes are driven only from buffer state, never from fu_* inputs
  always_comb begin
    lane_vld = '0;
    lane_res = '0;
    lane_src = '0;
    if (!rst) begin
      for (int k = 0; k < CDB_WIDTH; k++) begin
        for (int i = 0; i < NUM_FU; i++) begin
          if (grant[k][i]) begin
            lane_vld[k] = 1'b1;
            lane_res[k] = buf_data[i];
            lane_src[k] = FU_IDX_W'(i);
          end
        end
      end
    end
  end

  assign bus.cdb_valid  = lane_vld;
  assign bus.cdb_result = lane_res;
  assign bus.cdb_src    = lane_src;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= '0;
      buf_data  <= '0;
      rr_ptr    <= '0;
    end else begin
      // flush-cycle grants are real broadcasts, so the pointer still advances
      if (any_grant)
        rr_ptr <= (last_idx == FU_IDX_W'(NUM_FU-1)) ? '0 : last_idx + 1'b1;
      for (int i = 0; i < NUM_FU; i++) begin
        if (flush) begin
          buf_valid[i] <= 1'b0;
        end else if (bus.fu_valid[i] && bus.fu_ready[i]) begin
          buf_valid[i] <= 1'b1;
          buf_data[i]  <= bus.fu_result[i];
        end else if (granted[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end
endmodule
